itlb_refill_ctrl: RTL and testbench

ITLB_REFILL_CTRL -- requirements
Module: itlb_refill_ctrl

---
 rtl/itlb_refill_ctrl_pkg.sv | 24 ++
 rtl/itlb_refill_ctrl_walk_timer.sv | 28 ++
 rtl/itlb_refill_ctrl.sv | 172 +++++++++++++++++
 tb/tb_itlb_refill_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/itlb_refill_ctrl_pkg.sv
// Shared frontend definitions for the ITLB refill controller: FSM states,
// exception codes and page-number widths.
package itlb_refill_ctrl_pkg;

  localparam int VPN_W   = 20;
  localparam int PPN_W   = 20;
  localparam int VPN_LSB = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_FAULT,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'd0,
    EXC_PAGE_FAULT = 2'd1,
    EXC_TIMEOUT    = 2'd2
  } exc_e;

endpackage

// File: rtl/itlb_refill_ctrl_walk_timer.sv
// Saturating wait counter for an outstanding page walk; flags expiry once
// the count reaches TIMEOUT and holds there until cleared.
module walk_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(TIMEOUT);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != MAX_COUNT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q == MAX_COUNT);

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss handler: walks up to two missing pages (even/odd line halves)
// one at a time, writes the TLB on success and reports faults/timeouts.
module itlb_refill_ctrl
  import itlb_refill_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CLC_WIDTH = 26,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [CLC_WIDTH-1:0] lookup_clc_even,
  input  logic [CLC_WIDTH-1:0] lookup_clc_odd,
  input  logic                 hit_even,
  input  logic                 hit_odd,
  input  logic                 flush,
  output logic                 walk_req_valid,
  input  logic                 walk_req_ready,
  output logic [VPN_W-1:0]     walk_req_vpn,
  input  logic                 walk_resp_valid,
  input  logic [PPN_W-1:0]     walk_resp_ppn,
  input  logic                 walk_resp_fault,
  output logic                 fill_valid,
  output logic [VPN_W-1:0]     fill_vpn,
  output logic [PPN_W-1:0]     fill_ppn,
  output logic                 stall,
  output logic                 exception,
  output logic [1:0]           exception_type
);

  state_e           state_q;
  logic [VPN_W-1:0] vpn_even_q, vpn_odd_q;
  logic             pend_even_q, pend_odd_q;
  logic             walk_req_valid_q;
  logic [VPN_W-1:0] walk_req_vpn_q;
  logic             fill_valid_q;
  logic [VPN_W-1:0] fill_vpn_q;
  logic [PPN_W-1:0] fill_ppn_q;
  logic             exc_valid_q;
  exc_e             exc_type_q;

  logic             miss;
  logic [VPN_W-1:0] vpn_even_w, vpn_odd_w, cur_vpn;
  logic             new_pend_odd;
  logic             timer_expired;
  logic             unused;

  assign vpn_even_w   = lookup_clc_even[VPN_LSB +: VPN_W];
  assign vpn_odd_w    = lookup_clc_odd[VPN_LSB +: VPN_W];
  assign miss         = lookup_valid & (~hit_even | ~hit_odd);
  // Both halves on the same page need only one walk.
  assign new_pend_odd = ~hit_odd & ~(~hit_even & (vpn_odd_w == vpn_even_w));
  assign cur_vpn      = pend_even_q ? vpn_even_q : vpn_odd_q;
  assign unused       = ^{lookup_clc_even[VPN_LSB-1:0], lookup_clc_odd[VPN_LSB-1:0], (XLEN > 0)};

  walk_timer #(.TIMEOUT(TIMEOUT)) u_walk_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q != S_WAIT),
    .enable_i  (state_q == S_WAIT),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      vpn_even_q       <= '0;
      vpn_odd_q        <= '0;
      pend_even_q      <= 1'b0;
      pend_odd_q       <= 1'b0;
      walk_req_valid_q <= 1'b0;
      walk_req_vpn_q   <= '0;
      fill_valid_q     <= 1'b0;
      fill_vpn_q       <= '0;
      fill_ppn_q       <= '0;
      exc_valid_q      <= 1'b0;
      exc_type_q       <= EXC_NONE;
    end else begin
      fill_valid_q <= 1'b0;
      fill_vpn_q   <= '0;
      fill_ppn_q   <= '0;
      exc_valid_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (miss && !flush) begin
            vpn_even_q       <= vpn_even_w;
            vpn_odd_q        <= vpn_odd_w;
            pend_even_q      <= ~hit_even;
            pend_odd_q       <= new_pend_odd;
            walk_req_valid_q <= 1'b1;
            walk_req_vpn_q   <= ~hit_even ? vpn_even_w : vpn_odd_w;
            state_q          <= S_REQ;
          end
        end
        S_REQ: begin
          // A handshake coinciding with flush still leaves a walk in flight.
          if (walk_req_ready) begin
            walk_req_valid_q <= 1'b0;
            walk_req_vpn_q   <= '0;
            state_q          <= flush ? S_DRAIN : S_WAIT;
            if (flush) begin
              pend_even_q <= 1'b0;
              pend_odd_q  <= 1'b0;
            end
          end else if (flush) begin
            walk_req_valid_q <= 1'b0;
            walk_req_vpn_q   <= '0;
            pend_even_q      <= 1'b0;
            pend_odd_q       <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (flush) begin
            pend_even_q <= 1'b0;
            pend_odd_q  <= 1'b0;
            state_q     <= walk_resp_valid ? S_IDLE : S_DRAIN;
          end else if (walk_resp_valid && !walk_resp_fault) begin
            fill_valid_q <= 1'b1;
            fill_vpn_q   <= cur_vpn;
            fill_ppn_q   <= walk_resp_ppn;
            state_q      <= S_FILL;
          end else if (walk_resp_valid) begin
            exc_valid_q <= 1'b1;
            exc_type_q  <= EXC_PAGE_FAULT;
            state_q     <= S_FAULT;
          end else if (timer_expired) begin
            exc_valid_q <= 1'b1;
            exc_type_q  <= EXC_TIMEOUT;
            state_q     <= S_FAULT;
          end
        end
        S_FILL: begin
          if (!flush && pend_even_q && pend_odd_q) begin
            pend_even_q      <= 1'b0;
            walk_req_valid_q <= 1'b1;
            walk_req_vpn_q   <= vpn_odd_q;
            state_q          <= S_REQ;
          end else begin
            pend_even_q <= 1'b0;
            pend_odd_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_FAULT: begin
          // A timed-out walk is still owed a response, even under flush.
          pend_even_q <= 1'b0;
          pend_odd_q  <= 1'b0;
          exc_type_q  <= EXC_NONE;
          state_q     <= (exc_type_q == EXC_TIMEOUT) ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          if (walk_resp_valid) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall          = (state_q != S_IDLE) | (miss & ~flush);
  assign walk_req_valid = walk_req_valid_q;
  assign walk_req_vpn   = walk_req_vpn_q;
  assign fill_valid     = fill_valid_q & ~flush;
  assign fill_vpn       = fill_valid ? fill_vpn_q : '0;
  assign fill_ppn       = fill_valid ? fill_ppn_q : '0;
  assign exception      = exc_valid_q & ~flush;
  assign exception_type = exception ? exc_type_q : EXC_NONE;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Directed, table-driven bench for itlb_refill_ctrl: one vector per cycle,
// plus hand-written timeout and reset-mid-walk sequences.
module tb_itlb_refill_ctrl;

  typedef struct {
    logic        lv, he, ho;
    logic [19:0] ve, vo;
    logic        fl, rdy, rv;
    logic [19:0] ppn;
    logic        flt;
  } stim_t;

  typedef struct {
    logic [19:0] st, wrv, wv, fv, fvp, fpp, ex, et;
  } want_t;

  typedef struct {
    stim_t stim;
    want_t want;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [25:0] lookup_clc_even, lookup_clc_odd;
  logic        hit_even, hit_odd, flush;
  logic        walk_req_valid, walk_req_ready;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid;
  logic [19:0] walk_resp_ppn;
  logic        walk_resp_fault;
  logic        fill_valid;
  logic [19:0] fill_vpn, fill_ppn;
  logic        stall, exception;
  logic [1:0]  exception_type;

  int tests = 0;
  int failures = 0;
  vec_t tbl[$];
  stim_t idleIn;
  want_t zeroOut, stallOut;

  always #5 clk = ~clk;

  itlb_refill_ctrl #(.XLEN(32), .CLC_WIDTH(26), .TIMEOUT(255)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid    (lookup_valid),
    .lookup_clc_even (lookup_clc_even),
    .lookup_clc_odd  (lookup_clc_odd),
    .hit_even        (hit_even),
    .hit_odd         (hit_odd),
    .flush           (flush),
    .walk_req_valid  (walk_req_valid),
    .walk_req_ready  (walk_req_ready),
    .walk_req_vpn    (walk_req_vpn),
    .walk_resp_valid (walk_resp_valid),
    .walk_resp_ppn   (walk_resp_ppn),
    .walk_resp_fault (walk_resp_fault),
    .fill_valid      (fill_valid),
    .fill_vpn        (fill_vpn),
    .fill_ppn        (fill_ppn),
    .stall           (stall),
    .exception       (exception),
    .exception_type  (exception_type)
  );

  function automatic stim_t mkIn(input int lv, he, ho, ve, vo, fl, rdy, rv, ppn, flt);
    stim_t s;
    s.lv = lv[0]; s.he = he[0]; s.ho = ho[0];
    s.ve = ve[19:0]; s.vo = vo[19:0];
    s.fl = fl[0]; s.rdy = rdy[0]; s.rv = rv[0];
    s.ppn = ppn[19:0]; s.flt = flt[0];
    return s;
  endfunction

  function automatic want_t mkExp(input int st, wrv, wv, fv, fvp, fpp, ex, et);
    want_t w;
    w.st = st[19:0]; w.wrv = wrv[19:0]; w.wv = wv[19:0]; w.fv = fv[19:0];
    w.fvp = fvp[19:0]; w.fpp = fpp[19:0]; w.ex = ex[19:0]; w.et = et[19:0];
    return w;
  endfunction

  task automatic add(input stim_t s, input want_t w);
    vec_t v;
    v.stim = s;
    v.want = w;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    lookup_valid    = s.lv;
    hit_even        = s.he;
    hit_odd         = s.ho;
    lookup_clc_even = {s.ve, 6'h2A};
    lookup_clc_odd  = {s.vo, 6'h15};
    flush           = s.fl;
    walk_req_ready  = s.rdy;
    walk_resp_valid = s.rv;
    walk_resp_ppn   = s.ppn;
    walk_resp_fault = s.flt;
  endtask

  task automatic checkOne(input string name, input logic [19:0] act, input logic [19:0] want);
    tests++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic checkOutput(input want_t w, input string tag);
    checkOne({tag, ".stall"},          20'(stall),          w.st);
    checkOne({tag, ".walk_req_valid"}, 20'(walk_req_valid), w.wrv);
    checkOne({tag, ".walk_req_vpn"},   walk_req_vpn,        w.wv);
    checkOne({tag, ".fill_valid"},     20'(fill_valid),     w.fv);
    checkOne({tag, ".fill_vpn"},       fill_vpn,            w.fvp);
    checkOne({tag, ".fill_ppn"},       fill_ppn,            w.fpp);
    checkOne({tag, ".exception"},      20'(exception),      w.ex);
    checkOne({tag, ".exception_type"}, 20'(exception_type), w.et);
  endtask

  task automatic step(input stim_t s, input want_t w, input string tag);
    @(negedge clk);
    applyStimulus(s);
    #1;
    checkOutput(w, tag);
  endtask

  initial begin
    int n;
    bit found;
    idleIn   = mkIn(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    zeroOut  = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
    stallOut = mkExp(1, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    add(idleIn, zeroOut);
    // even miss, odd hit, response after three wait cycles
    add(mkIn(1, 0, 1, 'h12345, 'h12346, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h12345, 0, 0, 0, 0, 0));
    add(idleIn, stallOut);
    add(idleIn, stallOut);
    add(idleIn, stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h00ABC, 0), stallOut);
    add(idleIn, mkExp(1, 0, 0, 1, 'h12345, 'h00ABC, 0, 0));
    add(idleIn, zeroOut);
    // both miss, same page; stray response in REQ ignored, vpn held while not ready
    add(mkIn(1, 0, 0, 'h00040, 'h00040, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'hDEAD0, 0), mkExp(1, 1, 'h00040, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00040, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h55555, 0), stallOut);
    add(idleIn, mkExp(1, 0, 0, 1, 'h00040, 'h55555, 0, 0));
    add(idleIn, zeroOut);
    // both miss, distinct pages: even walk then odd walk
    add(mkIn(1, 0, 0, 'h00040, 'h00041, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00040, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h11111, 0), stallOut);
    add(idleIn, mkExp(1, 0, 0, 1, 'h00040, 'h11111, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00041, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h22222, 0), stallOut);
    add(idleIn, mkExp(1, 0, 0, 1, 'h00041, 'h22222, 0, 0));
    add(idleIn, zeroOut);
    // odd-only miss, walk faults
    add(mkIn(1, 1, 0, 'h00011, 'h0ABCD, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h0ABCD, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h33333, 1), stallOut);
    add(idleIn, mkExp(1, 0, 0, 0, 0, 0, 1, 1));
    add(idleIn, zeroOut);
    // both hit, miss under flush, stray response in IDLE
    add(mkIn(1, 1, 1, 5, 6, 0, 0, 0, 0, 0), zeroOut);
    add(mkIn(1, 0, 0, 5, 6, 1, 0, 0, 0, 0), zeroOut);
    add(idleIn, zeroOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h77777, 0), zeroOut);
    add(idleIn, zeroOut);
    // flush in REQ before handshake
    add(mkIn(1, 0, 1, 7, 8, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 1, 0, 0, 0, 0), mkExp(1, 1, 7, 0, 0, 0, 0, 0));
    add(idleIn, zeroOut);
    // flush in WAIT: drain until the response, no fill
    add(mkIn(1, 0, 1, 'h00099, 'h0009A, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00099, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 1, 0, 0, 0, 0), stallOut);
    add(idleIn, stallOut);
    add(idleIn, stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h44444, 0), stallOut);
    add(idleIn, zeroOut);
    add(idleIn, zeroOut);
    // flush in FILL suppresses the write
    add(mkIn(1, 0, 1, 'h00123, 'h00124, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00123, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h66666, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 1, 0, 0, 0, 0), stallOut);
    add(idleIn, zeroOut);
    // flush in FAULT suppresses the exception
    add(mkIn(1, 0, 1, 'h00321, 'h00322, 0, 0, 0, 0, 0), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00321, 0, 0, 0, 0, 0));
    add(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 0, 1), stallOut);
    add(mkIn(0, 1, 1, 0, 0, 1, 0, 0, 0, 0), stallOut);
    add(idleIn, zeroOut);

    applyStimulus(idleIn);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].stim, tbl[i].want, $sformatf("v%0d", i));
    end

    // walk timeout: fault after the counter saturates, then absorb the late response
    step(mkIn(1, 0, 1, 'h00200, 'h00201, 0, 0, 0, 0, 0), stallOut, "to_miss");
    step(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00200, 0, 0, 0, 0, 0), "to_req");
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(negedge clk);
      applyStimulus(idleIn);
      #1;
      if (exception === 1'b1) found = 1'b1;
      else n++;
    end
    checkOne("timeout_cycles", 20'(n), 20'd256);
    checkOutput(mkExp(1, 0, 0, 0, 0, 0, 1, 2), "to_fault");
    step(idleIn, stallOut, "to_drain0");
    step(idleIn, stallOut, "to_drain1");
    step(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h88888, 0), stallOut, "to_late_resp");
    step(idleIn, zeroOut, "to_idle");

    // reset while a walk is outstanding
    step(mkIn(1, 0, 1, 'h00300, 'h00301, 0, 0, 0, 0, 0), stallOut, "rst_miss");
    step(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00300, 0, 0, 0, 0, 0), "rst_req");
    step(idleIn, stallOut, "rst_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput(zeroOut, "rst_after");
    step(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h12121, 0), zeroOut, "rst_stray_resp");
    step(mkIn(1, 0, 1, 'h00400, 'h00401, 0, 0, 0, 0, 0), stallOut, "rst_new_miss");
    step(mkIn(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), mkExp(1, 1, 'h00400, 0, 0, 0, 0, 0), "rst_new_hold");
    step(mkIn(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), mkExp(1, 1, 'h00400, 0, 0, 0, 0, 0), "rst_new_req");
    step(mkIn(0, 1, 1, 0, 0, 0, 0, 1, 'h99999, 0), stallOut, "rst_new_resp");
    step(idleIn, mkExp(1, 0, 0, 1, 'h00400, 'h99999, 0, 0), "rst_new_fill");
    step(idleIn, zeroOut, "rst_new_idle");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
